// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields, EX/MEM destination snoop, and the registered EX-side copies.
// The pipeline drives the master side; the ID/EX register is the slave.
interface id_ex_stage_if #(
   parameter int DW   = 32,
   parameter int AOPW = 4
) ();
   logic            stall;
   logic            flush;

   logic            id_valid;
   logic [DW-1:0]   id_rs_data;
   logic [DW-1:0]   id_rt_data;
   logic [DW-1:0]   id_imm_ext;
   logic [DW-1:0]   id_pc;
   logic [4:0]      id_rs;
   logic [4:0]      id_rt;
   logic [4:0]      id_rd;
   logic            id_uses_rt;
   logic [1:0]      id_regdst;
   logic            id_alusrc;
   logic            id_memread;
   logic            id_memwrite;
   logic            id_regwrite;
   logic [1:0]      id_datatoreg;
   logic [AOPW-1:0] id_aluop;

   logic [4:0]      mem_dst;
   logic            mem_regwrite;

   logic [DW-1:0]   ex_rs_data;
   logic [DW-1:0]   ex_rt_data;
   logic [DW-1:0]   ex_imm_ext;
   logic [DW-1:0]   ex_pc;
   logic [4:0]      ex_rs;
   logic [4:0]      ex_rt;
   logic [4:0]      ex_rd;
   logic            ex_uses_rt;
   logic [1:0]      ex_regdst;
   logic            ex_alusrc;
   logic            ex_memread;
   logic            ex_memwrite;
   logic            ex_regwrite;
   logic [1:0]      ex_datatoreg;
   logic [AOPW-1:0] ex_aluop;
   logic [4:0]      ex_dst;
   logic            ex_valid;
   logic [1:0]      ex_forwardA;
   logic [1:0]      ex_forwardB;
   logic            load_use_stall;

   modport master (
      output stall, flush,
      output id_valid, id_rs_data, id_rt_data, id_imm_ext, id_pc,
      output id_rs, id_rt, id_rd, id_uses_rt, id_regdst,
      output id_alusrc, id_memread, id_memwrite, id_regwrite, id_datatoreg, id_aluop,
      output mem_dst, mem_regwrite,
      input  ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc,
      input  ex_rs, ex_rt, ex_rd, ex_uses_rt, ex_regdst,
      input  ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_datatoreg, ex_aluop,
      input  ex_dst, ex_valid, ex_forwardA, ex_forwardB, load_use_stall
   );

   modport slave (
      input  stall, flush,
      input  id_valid, id_rs_data, id_rt_data, id_imm_ext, id_pc,
      input  id_rs, id_rt, id_rd, id_uses_rt, id_regdst,
      input  id_alusrc, id_memread, id_memwrite, id_regwrite, id_datatoreg, id_aluop,
      input  mem_dst, mem_regwrite,
      output ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc,
      output ex_rs, ex_rt, ex_rd, ex_uses_rt, ex_regdst,
      output ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_datatoreg, ex_aluop,
      output ex_dst, ex_valid, ex_forwardA, ex_forwardB, load_use_stall
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: captures ID fields, predicts the
// EX operand forwards one cycle early, and bubbles EX on a load-use hazard.
module id_ex_stage #(
   parameter int DW   = 32,
   parameter int AOPW = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
);

   typedef struct packed {
      logic            valid;
      logic [DW-1:0]   rs_data;
      logic [DW-1:0]   rt_data;
      logic [DW-1:0]   imm_ext;
      logic [DW-1:0]   pc;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic            uses_rt;
      logic [1:0]      regdst;
      logic            alusrc;
      logic            memread;
      logic            memwrite;
      logic            regwrite;
      logic [1:0]      datatoreg;
      logic [AOPW-1:0] aluop;
      logic [4:0]      dst;
      logic [1:0]      fwd_a;
      logic [1:0]      fwd_b;
   } ex_t;

   ex_t        ex_q;
   ex_t        ex_d;
   logic [4:0] id_dst;
   logic       ex_hit_ok;
   logic       lus;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // The EX/MEM match is checked first so the youngest producer wins.
   function automatic logic [1:0] predict(input logic [4:0] src,
                                          input logic       ex_ok,
                                          input logic [4:0] ex_dst,
                                          input logic       mem_wr,
                                          input logic [4:0] mem_dst);
      if (src == 5'd0) return 2'b00;
      if (ex_ok && (ex_dst == src)) return 2'b10;
      if (mem_wr && (mem_dst == src)) return 2'b01;
      return 2'b00;
   endfunction

   always_comb begin
      id_dst = 5'd0;
      case (bus.id_regdst)
         2'b00:   id_dst = bus.id_rt;
         2'b01:   id_dst = bus.id_rd;
         2'b10:   id_dst = 5'd31;
         default: id_dst = 5'd0;
      endcase
      if (!bus.id_regwrite) id_dst = 5'd0;
   end

   always_comb begin
      ex_hit_ok = ex_q.valid & (ex_q.dst != 5'd0);
      lus       = ex_hit_ok & ex_q.memread & bus.id_valid &
                  ((ex_q.dst == bus.id_rs) | (bus.id_uses_rt & (ex_q.dst == bus.id_rt)));
      fwd_a     = predict(bus.id_rs, ex_hit_ok, ex_q.dst, bus.mem_regwrite, bus.mem_dst);
      fwd_b     = predict(bus.id_rt, ex_hit_ok, ex_q.dst, bus.mem_regwrite, bus.mem_dst);
   end

   // flush beats stall; a load-use bubble only applies when the pipe is advancing.
   always_comb begin
      ex_d = ex_q;
      if (bus.flush) begin
         ex_d = '0;
      end else if (bus.stall) begin
         ex_d = ex_q;
      end else if (lus) begin
         ex_d = '0;
      end else begin
         ex_d.valid     = bus.id_valid;
         ex_d.rs_data   = bus.id_rs_data;
         ex_d.rt_data   = bus.id_rt_data;
         ex_d.imm_ext   = bus.id_imm_ext;
         ex_d.pc        = bus.id_pc;
         ex_d.rs        = bus.id_rs;
         ex_d.rt        = bus.id_rt;
         ex_d.rd        = bus.id_rd;
         ex_d.uses_rt   = bus.id_uses_rt;
         ex_d.regdst    = bus.id_regdst;
         ex_d.alusrc    = bus.id_alusrc;
         ex_d.memread   = bus.id_memread;
         ex_d.memwrite  = bus.id_memwrite;
         ex_d.regwrite  = bus.id_regwrite;
         ex_d.datatoreg = bus.id_datatoreg;
         ex_d.aluop     = bus.id_aluop;
         ex_d.dst       = id_dst;
         ex_d.fwd_a     = fwd_a;
         ex_d.fwd_b     = fwd_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign bus.ex_valid       = ex_q.valid;
   assign bus.ex_rs_data     = ex_q.rs_data;
   assign bus.ex_rt_data     = ex_q.rt_data;
   assign bus.ex_imm_ext     = ex_q.imm_ext;
   assign bus.ex_pc          = ex_q.pc;
   assign bus.ex_rs          = ex_q.rs;
   assign bus.ex_rt          = ex_q.rt;
   assign bus.ex_rd          = ex_q.rd;
   assign bus.ex_uses_rt     = ex_q.uses_rt;
   assign bus.ex_regdst      = ex_q.regdst;
   assign bus.ex_alusrc      = ex_q.alusrc;
   assign bus.ex_memread     = ex_q.memread;
   assign bus.ex_memwrite    = ex_q.memwrite;
   assign bus.ex_regwrite    = ex_q.regwrite;
   assign bus.ex_datatoreg   = ex_q.datatoreg;
   assign bus.ex_aluop       = ex_q.aluop;
   assign bus.ex_dst         = ex_q.dst;
   assign bus.ex_forwardA    = ex_q.fwd_a;
   assign bus.ex_forwardB    = ex_q.fwd_b;
   assign bus.load_use_stall = lus;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each issued ID word pushes its expected EX image,
// which is popped and compared one clock later.
module tb_id_ex_stage;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [4:0]  rs, rt, rd;
      logic        uses_rt;
      logic [1:0]  regdst;
      logic        alusrc, memread, memwrite, regwrite;
      logic [1:0]  datatoreg;
      logic [3:0]  aluop;
      logic [31:0] pc, rsd, rtd, imm;
   } ins_t;

   typedef struct {
      logic        valid;
      logic [1:0]  fa, fb;
      logic [4:0]  dst;
      logic [31:0] pc, rsd;
      logic        memread, regwrite;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ins_t r_op(input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [31:0] pc);
      ins_t i;
      i.valid = 1'b1; i.rs = rs; i.rt = rt; i.rd = rd;
      i.uses_rt = 1'b1; i.regdst = 2'b01; i.alusrc = 1'b0;
      i.memread = 1'b0; i.memwrite = 1'b0; i.regwrite = 1'b1;
      i.datatoreg = 2'b00; i.aluop = 4'h2; i.pc = pc;
      i.rsd = 32'h1000 + 32'(rs); i.rtd = 32'h2000 + 32'(rt); i.imm = 32'h0;
      return i;
   endfunction

   function automatic ins_t lw_op(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] pc);
      ins_t i;
      i = r_op(5'd0, rs, rt, pc);
      i.uses_rt = 1'b0; i.regdst = 2'b00; i.alusrc = 1'b1; i.memread = 1'b1;
      i.datatoreg = 2'b01; i.aluop = 4'h0;
      return i;
   endfunction

   function automatic ins_t sw_op(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] pc);
      ins_t i;
      i = r_op(5'd0, rs, rt, pc);
      i.regdst = 2'b11; i.alusrc = 1'b1; i.memwrite = 1'b1; i.regwrite = 1'b0; i.aluop = 4'h0;
      return i;
   endfunction

   function automatic ins_t addi_op(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] pc);
      ins_t i;
      i = r_op(5'd0, rs, rt, pc);
      i.uses_rt = 1'b0; i.regdst = 2'b00; i.alusrc = 1'b1; i.imm = 32'h1; i.aluop = 4'h0;
      return i;
   endfunction

   function automatic exp_t cap(input ins_t i, input logic [4:0] dst,
                                input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      e.valid = i.valid; e.fa = fa; e.fb = fb; e.dst = dst;
      e.pc = i.pc; e.rsd = i.rsd; e.memread = i.memread; e.regwrite = i.regwrite;
      return e;
   endfunction

   function automatic exp_t bubble();
      exp_t e;
      e.valid = 1'b0; e.fa = 2'b00; e.fb = 2'b00; e.dst = 5'd0;
      e.pc = 32'h0; e.rsd = 32'h0; e.memread = 1'b0; e.regwrite = 1'b0;
      return e;
   endfunction

   task automatic drive(input ins_t i);
      bus.id_valid     = i.valid;
      bus.id_rs        = i.rs;
      bus.id_rt        = i.rt;
      bus.id_rd        = i.rd;
      bus.id_uses_rt   = i.uses_rt;
      bus.id_regdst    = i.regdst;
      bus.id_alusrc    = i.alusrc;
      bus.id_memread   = i.memread;
      bus.id_memwrite  = i.memwrite;
      bus.id_regwrite  = i.regwrite;
      bus.id_datatoreg = i.datatoreg;
      bus.id_aluop     = i.aluop;
      bus.id_pc        = i.pc;
      bus.id_rs_data   = i.rsd;
      bus.id_rt_data   = i.rtd;
      bus.id_imm_ext   = i.imm;
   endtask

   // One pipeline cycle; the bench's own EX/MEM register follows whatever left EX.
   task automatic step(input string tag, input ins_t i, input logic st, input logic fl,
                       input logic exp_lus, input exp_t e);
      logic [4:0] nxt_mdst;
      logic       nxt_mwr;
      exp_t       got;
      drive(i);
      bus.stall = st;
      bus.flush = fl;
      #1;
      chk({tag, ":load_use"}, 32'(bus.load_use_stall), 32'(exp_lus));
      exp_q.push_back(e);
      nxt_mwr  = bus.ex_valid & bus.ex_regwrite;
      nxt_mdst = nxt_mwr ? bus.ex_dst : 5'd0;
      @(posedge clk);
      #1;
      if (!st) begin
         bus.mem_dst      = nxt_mdst;
         bus.mem_regwrite = nxt_mwr;
      end
      if (exp_q.size() == 0) begin
         chk({tag, ":queue"}, 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         chk({tag, ":valid"},    32'(bus.ex_valid),    32'(got.valid));
         chk({tag, ":fwdA"},     32'(bus.ex_forwardA), 32'(got.fa));
         chk({tag, ":fwdB"},     32'(bus.ex_forwardB), 32'(got.fb));
         chk({tag, ":dst"},      32'(bus.ex_dst),      32'(got.dst));
         chk({tag, ":pc"},       bus.ex_pc,            got.pc);
         chk({tag, ":rs_data"},  bus.ex_rs_data,       got.rsd);
         chk({tag, ":memread"},  32'(bus.ex_memread),  32'(got.memread));
         chk({tag, ":regwrite"}, 32'(bus.ex_regwrite), 32'(got.regwrite));
      end
   endtask

   initial begin
      ins_t i;
      exp_t held;
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      i = r_op(5'd0, 5'd0, 5'd0, 32'h0);
      i.valid = 1'b0; i.regwrite = 1'b0; i.uses_rt = 1'b0; i.regdst = 2'b00;
      i.aluop = 4'h0; i.rsd = 32'h0; i.rtd = 32'h0;
      drive(i);
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.mem_dst = 5'd0;
      bus.mem_regwrite = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst:valid", 32'(bus.ex_valid),    32'd0);
      chk("rst:fwdA",  32'(bus.ex_forwardA), 32'd0);
      chk("rst:pc",    bus.ex_pc,            32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      step("add",      r_op(5'd3, 5'd1, 5'd2, 32'h100), 0, 0, 0, cap(r_op(5'd3, 5'd1, 5'd2, 32'h100), 5'd3, 2'b00, 2'b00));
      step("sub_fwd",  r_op(5'd4, 5'd3, 5'd5, 32'h104), 0, 0, 0, cap(r_op(5'd4, 5'd3, 5'd5, 32'h104), 5'd4, 2'b10, 2'b00));
      step("nop1",     r_op(5'd0, 5'd0, 5'd0, 32'h108), 0, 0, 0, cap(r_op(5'd0, 5'd0, 5'd0, 32'h108), 5'd0, 2'b00, 2'b00));
      step("add2",     r_op(5'd3, 5'd1, 5'd2, 32'h10c), 0, 0, 0, cap(r_op(5'd3, 5'd1, 5'd2, 32'h10c), 5'd3, 2'b00, 2'b00));
      step("nop2",     r_op(5'd0, 5'd0, 5'd0, 32'h110), 0, 0, 0, cap(r_op(5'd0, 5'd0, 5'd0, 32'h110), 5'd0, 2'b00, 2'b00));
      step("or_fwd",   r_op(5'd6, 5'd7, 5'd3, 32'h114), 0, 0, 0, cap(r_op(5'd6, 5'd7, 5'd3, 32'h114), 5'd6, 2'b00, 2'b01));
      step("lw",       lw_op(5'd8, 5'd1, 32'h118),      0, 0, 0, cap(lw_op(5'd8, 5'd1, 32'h118), 5'd8, 2'b00, 2'b00));
      step("lu_bub",   r_op(5'd9, 5'd8, 5'd8, 32'h11c), 0, 0, 1, bubble());
      step("lu_fwd",   r_op(5'd9, 5'd8, 5'd8, 32'h11c), 0, 0, 0, cap(r_op(5'd9, 5'd8, 5'd8, 32'h11c), 5'd9, 2'b01, 2'b01));
      step("lw2",      lw_op(5'd2, 5'd5, 32'h120),      0, 0, 0, cap(lw_op(5'd2, 5'd5, 32'h120), 5'd2, 2'b00, 2'b00));
      step("sw_lu",    sw_op(5'd2, 5'd6, 32'h124),      0, 0, 1, bubble());
      step("sw_fwd",   sw_op(5'd2, 5'd6, 32'h124),      0, 0, 0, cap(sw_op(5'd2, 5'd6, 32'h124), 5'd0, 2'b00, 2'b01));
      step("lw3",      lw_op(5'd2, 5'd5, 32'h128),      0, 0, 0, cap(lw_op(5'd2, 5'd5, 32'h128), 5'd2, 2'b00, 2'b00));
      held = cap(addi_op(5'd2, 5'd6, 32'h12c), 5'd2, 2'b00, 2'b10);
      step("addi_nolu", addi_op(5'd2, 5'd6, 32'h12c),   0, 0, 0, held);

      for (int k = 0; k < 3; k++)
         step("stall_hold", r_op(5'd10, 5'd2, 5'd2, 32'h130), 1, 0, 0, held);
      step("flush_stall", r_op(5'd10, 5'd2, 5'd2, 32'h130), 1, 1, 0, bubble());
      step("post_stall",  r_op(5'd10, 5'd2, 5'd2, 32'h130), 0, 0, 0, cap(r_op(5'd10, 5'd2, 5'd2, 32'h130), 5'd10, 2'b01, 2'b01));
      step("lw11",        lw_op(5'd11, 5'd1, 32'h134),      0, 0, 0, cap(lw_op(5'd11, 5'd1, 32'h134), 5'd11, 2'b00, 2'b00));
      step("flush_lu",    r_op(5'd12, 5'd11, 5'd3, 32'h138), 0, 1, 1, bubble());
      step("after_lu",    r_op(5'd12, 5'd11, 5'd3, 32'h138), 0, 0, 0, cap(r_op(5'd12, 5'd11, 5'd3, 32'h138), 5'd12, 2'b01, 2'b00));
      step("fwd_both",    r_op(5'd13, 5'd12, 5'd12, 32'h13c), 0, 0, 0, cap(r_op(5'd13, 5'd12, 5'd12, 32'h13c), 5'd13, 2'b10, 2'b10));

      i = r_op(5'd5, 5'd12, 5'd0, 32'h140);
      i.regdst = 2'b10;
      step("jal_r31", i, 0, 0, 0, cap(i, 5'd31, 2'b01, 2'b00));
      i = r_op(5'd7, 5'd31, 5'd0, 32'h144);
      i.regwrite = 1'b0;
      step("no_wr", i, 0, 0, 0, cap(i, 5'd0, 2'b10, 2'b00));

      // Asynchronous reset between clock edges while EX holds a valid instruction.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst:valid",   32'(bus.ex_valid),    32'd0);
      chk("arst:fwdA",    32'(bus.ex_forwardA), 32'd0);
      chk("arst:pc",      bus.ex_pc,            32'd0);
      chk("arst:rs_data", bus.ex_rs_data,       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
